tile_table_ctrl: RTL and testbench
==================================

Name: tile_table_ctrl

Overview:
- Owns the 40x30 game tile table (one sprite code per cell) between the game-logic FSM and the video renderer.
- Accepts cell writes (update/posx/posy/sprite) and cell reads (get/ready/read_sprite) from the game logic.
- Serves per-cell lookups to the video scan path.
- Arbitrates all three onto one single-port RAM and clears the table after reset.

Parameters:
- COLS, 40, table width in cells (max 64).
- ROWS, 30, table height in cells (max 64).
- DW, 8, sprite code width.
- FILL, 8'd0, value written to every cell by the post-reset clear.

Ports:
- px_clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- update  in  1  game-side write request (level; a write is issued on its rising edge).
- posx  in  6  cell column for write/read.
- posy  in  6  cell row for write/read.
- sprite  in  DW  write data.
- get  in  1  game-side read request (level; held until ready is seen).
- ready  out  1  read data valid; held while get is high.
- read_sprite  out  DW  read data; stable while ready is high.
- vid_req  in  1  video lookup strobe, one cycle per lookup.
- vid_x  in  6  video cell column.
- vid_y  in  6  video cell row.
- vid_sprite  out  DW  video lookup result.
- vid_valid  out  1  pulses one cycle after the accepted vid_req.
- busy  out  1  high while the post-reset clear is running.

Behaviour:
- Reset (rst=0 at a px_clk edge):
  - ready=0, read_sprite=0, vid_valid=0, vid_sprite=0, busy=1.
  - Pending write is dropped; edge detectors are cleared; state goes to CLEAR with clear counter = 0.
  - Reset applied mid-operation aborts everything, with no partial handshake completion.
- Address: addr = posy*COLS + posx, computed as (y<<5)+(y<<3)+x for COLS=40; 11 bits; max 1199.
  - A coordinate is out of range if x>=COLS or y>=ROWS.
- RAM: single port, 1-cycle read latency, COLS*ROWS x DW. One access per cycle.
- Access priority, each cycle: video > clear > pending write > read.
- Video path:
  - A vid_req cycle always wins the RAM port.
  - vid_valid=1 and vid_sprite=data exactly 1 cycle later.
  - Out-of-range vid coordinates return FILL with vid_valid.
  - Video is serviced in every state, including CLEAR; cells not yet cleared return stale contents.
- States: CLEAR, IDLE, RD_ISSUE, RD_DATA, RD_HOLD.
- CLEAR:
  - Writes FILL to counter address on every cycle without vid_req; counter increments.
  - Last write at 1199 -> IDLE, busy drops to 0 on the following cycle (1200 cycles minimum with no video).
  - update/get edges arriving during CLEAR are held pending and serviced after.
- Write path:
  - update rising edge latches {addr, sprite} into a 1-deep pending buffer.
  - A pending write is committed on the first cycle with no vid_req and not in CLEAR.
  - A new rising edge before commit overwrites the buffer (latest wins).
  - Out-of-range writes are discarded at latch time.
  - update held high issues exactly one write.
- Read path:
  - get rising edge in IDLE latches addr -> RD_ISSUE.
  - RD_ISSUE issues the RAM read when the port is free (no vid_req, no pending write); a pending write to the same cell commits first, giving read-after-write ordering.
  - RD_DATA captures read_sprite and sets ready=1 -> RD_HOLD.
  - RD_HOLD keeps ready=1 until get=0, then ready=0 the next cycle -> IDLE.
  - Out-of-range read: RD_ISSUE -> RD_DATA with read_sprite=FILL and no RAM access.
  - Minimum latency: get edge to ready = 3 cycles with an uncontended port.
  - get dropping before ready aborts the read: return to IDLE, ready stays 0.
- Simultaneous update and get rising edges: the write is latched and the read is served after it commits, so the read returns the new value for the same cell.
- Write data and address are sampled only at edge-detect time; later changes to posx/posy/sprite do not alter a pending op.

Test Plan:
- Release rst, no vid_req -> busy=1 for 1200 cycles then 0; every cell read via get returns 8'd0.
- After clear: write (5,6)=8'h07 via update pulse, then get at (5,6) -> ready after 3 cycles, read_sprite=8'h07; ready stays high until get=0, then falls next cycle.
- vid_req continuously high for 10 cycles during a pending write and a get -> vid_valid every cycle with correct data; write commits and ready rises only after vid_req drops.
- update and get rise in the same cycle at (39,29) with sprite=8'h42 -> read_sprite=8'h42; write at (40,0) is ignored and a get at (40,0) returns 8'h00.
- update held high 50 cycles while sprite changes -> only the value at the rising edge is stored; two update pulses before commit (vid_req held) -> only the second value is stored.
- Assert rst=0 during RD_HOLD and mid-CLEAR -> next cycle ready=0, vid_valid=0, busy=1, clear restarts at address 0.

Source files
------------

// File: rtl/tile_table_ctrl.sv
// tile_table_ctrl: owns the COLS x ROWS sprite-code tile table and shares its
// single-port RAM between video lookups, the post-reset clear, game-side
// cell writes and game-side cell reads (priority in that order).
//
// Ports:
//   px_clk       pixel clock (only clock)
//   rst          synchronous reset, active low
//   update       game write request (level, rising edge issues one write)
//   posx, posy   game cell coordinate for writes and reads
//   sprite       game write data
//   get          game read request (level, held until ready is seen)
//   ready        read data valid, held while get stays high
//   read_sprite  read data, stable while ready is high
//   vid_req      video lookup strobe, one cycle per lookup
//   vid_x, vid_y video cell coordinate
//   vid_sprite   video lookup result
//   vid_valid    pulses one cycle after each vid_req
//   busy         high while the post-reset clear runs
module tile_table_ctrl #(
  parameter int unsigned    COLS = 40,
  parameter int unsigned    ROWS = 30,
  parameter int unsigned    DW   = 8,
  parameter logic [DW-1:0]  FILL = '0
) (
  input  logic          px_clk,
  input  logic          rst,
  input  logic          update,
  input  logic [5:0]    posx,
  input  logic [5:0]    posy,
  input  logic [DW-1:0] sprite,
  input  logic          get,
  output logic          ready,
  output logic [DW-1:0] read_sprite,
  input  logic          vid_req,
  input  logic [5:0]    vid_x,
  input  logic [5:0]    vid_y,
  output logic [DW-1:0] vid_sprite,
  output logic          vid_valid,
  output logic          busy
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_RD_ISSUE,
    S_RD_DATA,
    S_RD_HOLD
  } state_e;

  function automatic logic in_range(input logic [5:0] x, input logic [5:0] y);
    return (32'(x) < COLS) && (32'(y) < ROWS);
  endfunction

  // Row-major cell index; for COLS=40 this reduces to (y<<5)+(y<<3)+x.
  function automatic logic [AW-1:0] cell_addr(input logic [5:0] x, input logic [5:0] y);
    return AW'(32'(y) * COLS + 32'(x));
  endfunction

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            upd_prev_q, upd_prev_d;
  logic            get_prev_q, get_prev_d;
  logic            wr_pend_q, wr_pend_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            rd_pend_q, rd_pend_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            rd_oor_q, rd_oor_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            ready_q, ready_d;
  logic [DW-1:0]   read_sprite_q, read_sprite_d;
  logic            vid_valid_q, vid_valid_d;
  logic [DW-1:0]   vid_sprite_q, vid_sprite_d;
  logic            busy_q, busy_d;

  logic            upd_rise_c, get_rise_c;
  logic            vid_in_rng_c, pos_in_rng_c;
  logic            clr_go_c, wr_go_c, rd_go_c;
  logic            ram_we_c;
  logic [AW-1:0]   ram_addr_c;
  logic [DW-1:0]   ram_wdata_c;
  logic [DW-1:0]   ram_rdata_c;

  logic [DW-1:0]   mem [CELLS];

  assign upd_rise_c   = update & ~upd_prev_q;
  assign get_rise_c   = get & ~get_prev_q;
  assign vid_in_rng_c = in_range(vid_x, vid_y);
  assign pos_in_rng_c = in_range(posx, posy);

  // Port arbitration: video > clear > pending write > game read.
  always_comb begin
    clr_go_c    = 1'b0;
    wr_go_c     = 1'b0;
    rd_go_c     = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = FILL;
    if (vid_req) begin
      if (vid_in_rng_c) ram_addr_c = cell_addr(vid_x, vid_y);
    end else if (state_q == S_CLEAR) begin
      clr_go_c   = 1'b1;
      ram_we_c   = 1'b1;
      ram_addr_c = clr_cnt_q;
    end else if (wr_pend_q) begin
      wr_go_c     = 1'b1;
      ram_we_c    = 1'b1;
      ram_addr_c  = wr_addr_q;
      ram_wdata_c = wr_data_q;
    end else if ((state_q == S_RD_ISSUE) && !rd_oor_q) begin
      rd_go_c    = 1'b1;
      ram_addr_c = rd_addr_q;
    end
  end

  // Single-port RAM array; its read data is captured by vid_sprite_q or rd_data_q.
  assign ram_rdata_c = mem[ram_addr_c];

  always_ff @(posedge px_clk) begin
    if (rst && ram_we_c) mem[ram_addr_c] <= ram_wdata_c;
  end

  // Next-state and datapath.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    upd_prev_d    = update;
    get_prev_d    = get;
    wr_pend_d     = wr_pend_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    rd_pend_d     = rd_pend_q;
    rd_addr_d     = rd_addr_q;
    rd_oor_d      = rd_oor_q;
    rd_data_d     = rd_data_q;
    ready_d       = ready_q;
    read_sprite_d = read_sprite_q;
    vid_valid_d   = vid_req;
    vid_sprite_d  = vid_sprite_q;

    if (vid_req) vid_sprite_d = vid_in_rng_c ? ram_rdata_c : FILL;

    // Commit frees the buffer; a new edge in the same cycle refills it (latest wins).
    if (wr_go_c) wr_pend_d = 1'b0;
    if (upd_rise_c && pos_in_rng_c) begin
      wr_pend_d = 1'b1;
      wr_addr_d = cell_addr(posx, posy);
      wr_data_d = sprite;
    end

    case (state_q)
      S_CLEAR: begin
        // A read edge seen during clear is remembered and served once idle.
        if (get_rise_c) begin
          rd_pend_d = 1'b1;
          rd_oor_d  = ~pos_in_rng_c;
          rd_addr_d = pos_in_rng_c ? cell_addr(posx, posy) : '0;
        end
        if (clr_go_c) begin
          clr_cnt_d = clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(CELLS - 1)) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        rd_pend_d = 1'b0;
        if (get_rise_c) begin
          rd_oor_d  = ~pos_in_rng_c;
          rd_addr_d = pos_in_rng_c ? cell_addr(posx, posy) : '0;
          state_d   = S_RD_ISSUE;
        end else if (rd_pend_q && get) begin
          state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        if (!get) begin
          state_d = S_IDLE;
        end else if (rd_oor_q) begin
          rd_data_d = FILL;
          state_d   = S_RD_DATA;
        end else if (rd_go_c) begin
          rd_data_d = ram_rdata_c;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (!get) begin
          state_d = S_IDLE;
        end else begin
          read_sprite_d = rd_data_q;
          ready_d       = 1'b1;
          state_d       = S_RD_HOLD;
        end
      end
      S_RD_HOLD: begin
        if (!get) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge px_clk) begin
    if (!rst) begin
      state_q       <= S_CLEAR;
      clr_cnt_q     <= '0;
      upd_prev_q    <= 1'b0;
      get_prev_q    <= 1'b0;
      wr_pend_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_pend_q     <= 1'b0;
      rd_addr_q     <= '0;
      rd_oor_q      <= 1'b0;
      rd_data_q     <= '0;
      ready_q       <= 1'b0;
      read_sprite_q <= '0;
      vid_valid_q   <= 1'b0;
      vid_sprite_q  <= '0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      upd_prev_q    <= upd_prev_d;
      get_prev_q    <= get_prev_d;
      wr_pend_q     <= wr_pend_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_pend_q     <= rd_pend_d;
      rd_addr_q     <= rd_addr_d;
      rd_oor_q      <= rd_oor_d;
      rd_data_q     <= rd_data_d;
      ready_q       <= ready_d;
      read_sprite_q <= read_sprite_d;
      vid_valid_q   <= vid_valid_d;
      vid_sprite_q  <= vid_sprite_d;
      busy_q        <= busy_d;
    end
  end

  assign ready       = ready_q;
  assign read_sprite = read_sprite_q;
  assign vid_valid   = vid_valid_q;
  assign vid_sprite  = vid_sprite_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tile_table_ctrl.sv
// Self-checking bench for tile_table_ctrl: table-driven write/read vectors,
// hand-written multi-cycle corner sequences and a randomized write/video phase
// checked against a cell-array reference model.
module tb_tile_table_ctrl;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic       px_clk = 1'b0;
  logic       rst;
  logic       update;
  logic [5:0] posx, posy;
  logic [7:0] sprite;
  logic       get;
  logic       ready;
  logic [7:0] read_sprite;
  logic       vid_req;
  logic [5:0] vid_x, vid_y;
  logic [7:0] vid_sprite;
  logic       vid_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [CELLS];

  always #5 px_clk = ~px_clk;

  tile_table_ctrl dut (
    .px_clk      (px_clk),
    .rst         (rst),
    .update      (update),
    .posx        (posx),
    .posy        (posy),
    .sprite      (sprite),
    .get         (get),
    .ready       (ready),
    .read_sprite (read_sprite),
    .vid_req     (vid_req),
    .vid_x       (vid_x),
    .vid_y       (vid_y),
    .vid_sprite  (vid_sprite),
    .vid_valid   (vid_valid),
    .busy        (busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input int x, input int y);
    if (x < COLS && y < ROWS) return model[y * COLS + x];
    return 8'h00;
  endfunction

  task automatic model_wr(input int x, input int y, input logic [7:0] d);
    if (x < COLS && y < ROWS) model[y * COLS + x] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) model[i] = 8'h00;
  endtask

  // Count cycles from the reset edge until busy drops.
  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'd1200);
  endtask

  task automatic write_cell(input int x, input int y, input logic [7:0] d);
    posx = 6'(x); posy = 6'(y); sprite = d; update = 1'b1;
    tick();
    update = 1'b0;
    tick();
    model_wr(x, y, d);
  endtask

  // lat = cycles from raising get to seeing ready, or -1 on timeout.
  task automatic read_cell(input int x, input int y, output logic [7:0] d, output int lat);
    posx = 6'(x); posy = 6'(y); get = 1'b1; lat = 0;
    do begin
      tick();
      lat++;
    end while (!ready && lat < 100);
    d = read_sprite;
    if (!ready) lat = -1;
    get = 1'b0;
    tick();
  endtask

  task automatic read_expect(input string name, input int x, input int y,
                             input logic [7:0] exp, input int exp_lat);
    logic [7:0] d;
    int lat;
    read_cell(x, y, d, lat);
    check({name, "_ready_seen"}, 32'(lat > 0), 32'd1);
    check({name, "_data"}, 32'(d), 32'(exp));
    if (exp_lat > 0) check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_ready_fall"}, 32'(ready), 32'd0);
  endtask

  // Back-to-back video lookups over the whole table against the model.
  task automatic vid_sweep(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      vid_req = 1'b1; vid_x = 6'(i % COLS); vid_y = 6'(i / COLS);
      tick();
      if (vid_valid !== 1'b1 || vid_sprite !== model[i]) bad++;
    end
    vid_req = 1'b0;
    tick();
    check(name, 32'(bad), 32'd0);
    check({name, "_valid_drop"}, 32'(vid_valid), 32'd0);
  endtask

  typedef struct {
    int         x;
    int         y;
    bit         wr;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [7:0] d;
    int lat, bad, n;
    logic [7:0] old;
    logic       mpend, upd_prev_m, vreq_prev;
    int         mx, my;
    logic [7:0] md, exp_vid;

    vecs[0]  = '{x: 5,  y: 6,  wr: 1'b1, d: 8'h07, exp: 8'h07};
    vecs[1]  = '{x: 0,  y: 0,  wr: 1'b1, d: 8'hA1, exp: 8'hA1};
    vecs[2]  = '{x: 39, y: 0,  wr: 1'b1, d: 8'hB2, exp: 8'hB2};
    vecs[3]  = '{x: 0,  y: 29, wr: 1'b1, d: 8'hC3, exp: 8'hC3};
    vecs[4]  = '{x: 39, y: 29, wr: 1'b1, d: 8'hD4, exp: 8'hD4};
    vecs[5]  = '{x: 40, y: 0,  wr: 1'b1, d: 8'hAA, exp: 8'h00};
    vecs[6]  = '{x: 0,  y: 1,  wr: 1'b0, d: 8'h00, exp: 8'h00};
    vecs[7]  = '{x: 0,  y: 30, wr: 1'b1, d: 8'hBB, exp: 8'h00};
    vecs[8]  = '{x: 63, y: 63, wr: 1'b1, d: 8'hCC, exp: 8'h00};
    vecs[9]  = '{x: 0,  y: 0,  wr: 1'b0, d: 8'h00, exp: 8'hA1};
    vecs[10] = '{x: 5,  y: 6,  wr: 1'b1, d: 8'hF0, exp: 8'hF0};

    rst = 1'b0; update = 1'b0; get = 1'b0; posx = '0; posy = '0; sprite = '0;
    vid_req = 1'b0; vid_x = '0; vid_y = '0;
    model_clear();

    // Reset state
    tick(); tick();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_read_sprite", 32'(read_sprite), 32'd0);
    check("rst_vid_valid", 32'(vid_valid), 32'd0);
    check("rst_vid_sprite", 32'(vid_sprite), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    wait_clear("clear_cycles");

    // Every cell reads back the fill value
    bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      read_cell(i % COLS, i / COLS, d, lat);
      if (lat < 0 || d !== 8'h00) bad++;
    end
    check("clear_get_all", 32'(bad), 32'd0);
    vid_sweep("clear_vid_sweep");

    // Table-driven write/read vectors
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) write_cell(vecs[i].x, vecs[i].y, vecs[i].d);
      read_expect($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].exp, 3);
    end

    // ready held while get stays high, data stable even if posx changes
    posx = 6'd5; posy = 6'd6; get = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ready && n < 100);
    check("hold_latency", 32'(n), 32'd3);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      posx = 6'(i);
      tick();
      if (ready !== 1'b1 || read_sprite !== 8'hF0) bad++;
    end
    check("hold_stable", 32'(bad), 32'd0);
    get = 1'b0;
    tick();
    check("hold_ready_fall", 32'(ready), 32'd0);

    // Video contention: vid_req held 10 cycles across a pending write and a get
    old = model_rd(3, 3);
    vid_req = 1'b1; vid_x = 6'd3; vid_y = 6'd3;
    posx = 6'd3; posy = 6'd3; sprite = 8'h33; update = 1'b1; get = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (vid_valid !== 1'b1 || vid_sprite !== old || ready !== 1'b0) bad++;
      update = 1'b0;
    end
    check("contend_vid_and_stall", 32'(bad), 32'd0);
    vid_req = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!ready && n < 100);
    check("contend_latency", 32'(n), 32'd3);
    check("contend_raw_data", 32'(read_sprite), 32'h33);
    get = 1'b0;
    tick();
    model_wr(3, 3, 8'h33);

    // Simultaneous update/get edges at the far corner
    posx = 6'd39; posy = 6'd29; sprite = 8'h42; update = 1'b1; get = 1'b1;
    n = 0;
    do begin tick(); n++; update = 1'b0; end while (!ready && n < 100);
    check("same_edge_ready_seen", 32'(ready), 32'd1);
    check("same_edge_data", 32'(read_sprite), 32'h42);
    get = 1'b0;
    tick();
    model_wr(39, 29, 8'h42);
    write_cell(40, 0, 8'h99);
    read_expect("oor_40_0", 40, 0, 8'h00, 3);

    // Out-of-range video lookups return fill with valid
    vid_req = 1'b1; vid_x = 6'd40; vid_y = 6'd0;
    tick();
    check("vid_oor_x_valid", 32'(vid_valid), 32'd1);
    check("vid_oor_x_data", 32'(vid_sprite), 32'd0);
    vid_x = 6'd0; vid_y = 6'd30;
    tick();
    check("vid_oor_y_data", 32'(vid_sprite), 32'd0);
    vid_req = 1'b0;
    tick();

    // update held high: only the rising-edge value is stored
    posx = 6'd8; posy = 6'd8; sprite = 8'h55; update = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) begin
      sprite = 8'($urandom);
      tick();
    end
    update = 1'b0;
    tick();
    model_wr(8, 8, 8'h55);
    read_expect("held_update", 8, 8, 8'h55, 3);

    // Two update pulses before commit: latest wins
    vid_req = 1'b1; vid_x = 6'd0; vid_y = 6'd0;
    posx = 6'd7; posy = 6'd7; sprite = 8'h11; update = 1'b1;
    tick(); update = 1'b0; tick();
    sprite = 8'h22; update = 1'b1;
    tick(); update = 1'b0; tick();
    vid_req = 1'b0;
    tick();
    model_wr(7, 7, 8'h22);
    read_expect("latest_wins", 7, 7, 8'h22, 3);

    // get dropped before ready aborts the read
    posx = 6'd5; posy = 6'd6; get = 1'b1;
    tick();
    get = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ready !== 1'b0) bad++;
    end
    check("abort_no_ready", 32'(bad), 32'd0);
    read_expect("after_abort", 5, 6, 8'hF0, 3);

    // Randomized writes and video lookups against the model
    mpend = 1'b0; upd_prev_m = 1'b0; vreq_prev = 1'b0;
    mx = 0; my = 0; md = 8'h00; exp_vid = 8'h00;
    for (int c = 0; c < 600; c++) begin
      vid_req = 1'($urandom % 2);
      vid_x = 6'($urandom % 46); vid_y = 6'($urandom % 34);
      if ($urandom % 3 == 0) update = ~update;
      posx = 6'($urandom % 43); posy = 6'($urandom % 32); sprite = 8'($urandom);
      if (vid_req) exp_vid = model_rd(int'(vid_x), int'(vid_y));
      else if (mpend) begin
        model_wr(mx, my, md);
        mpend = 1'b0;
      end
      if (update && !upd_prev_m && int'(posx) < COLS && int'(posy) < ROWS) begin
        mpend = 1'b1; mx = int'(posx); my = int'(posy); md = sprite;
      end
      upd_prev_m = update;
      vreq_prev = vid_req;
      tick();
      check("rand_vid_valid", 32'(vid_valid), 32'(vreq_prev));
      if (vreq_prev) check("rand_vid_data", 32'(vid_sprite), 32'(exp_vid));
    end
    update = 1'b0; vid_req = 1'b0;
    tick();
    if (mpend) model_wr(mx, my, md);
    tick();
    vid_sweep("rand_vid_sweep");
    for (int i = 0; i < 8; i++) begin
      mx = int'($urandom % COLS); my = int'($urandom % ROWS);
      read_expect($sformatf("rand_get%0d", i), mx, my, model_rd(mx, my), 3);
    end

    // Reset during RD_HOLD with a video request in flight
    posx = 6'd8; posy = 6'd8; get = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!ready && n < 100);
    check("rsthold_ready_seen", 32'(ready), 32'd1);
    vid_req = 1'b1; rst = 1'b0;
    tick();
    check("rsthold_ready", 32'(ready), 32'd0);
    check("rsthold_vid_valid", 32'(vid_valid), 32'd0);
    check("rsthold_busy", 32'(busy), 32'd1);
    check("rsthold_read_sprite", 32'(read_sprite), 32'd0);
    rst = 1'b1; vid_req = 1'b0; get = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    check("midclear_busy", 32'(busy), 32'd1);

    // Reset mid-clear restarts the full clear from address 0
    rst = 1'b0;
    tick();
    check("midclear_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    wait_clear("reclear_cycles");
    model_clear();
    read_expect("reclear_cell", 8, 8, 8'h00, 3);
    vid_sweep("reclear_vid_sweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
